uart_rx: RTL

//  8N1 UART receiver; counterpart of the team's UART transmitter, same baud divisor and framing.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_rx_sync.sv | 12 +
 rtl/uart_rx.sv | 90 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and baud divisor shared with the UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, RECV} rx_state_t;
  localparam int BAUD_DIV_DEFAULT = 2604;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous RX pin, resets to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk)
    s_q <= rst ? 2'b11 : {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and sticky rdy flag.
// Define UART_RX_FRM_ERR_EN to report a low stop bit on frm_err.
import uart_pkg::*;
module uart_rx #(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);
  // counters are loaded with N-1 and sample at 0, so each interval is exactly N clocks
  localparam logic [11:0] HALF_LD = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] BAUD_LD = 12'(BAUD_DIV - 1);
  rx_state_t   state_q, state_d;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  shft_q, shft_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        rx_s, rx_d_q, fall, start, done;
  uart_rx_sync u_sync (.clk(clk), .rst(rst), .d_i(RX), .q_o(rx_s));
  assign fall = rx_d_q & ~rx_s;
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shft_d  = shft_q;
    data_d  = data_q;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        baud_d  = HALF_LD;
        bit_d   = 4'd0;
        start   = 1'b1;
      end
      START: if (baud_q == 12'd0) begin
        state_d = rx_s ? IDLE : RECV;
        baud_d  = BAUD_LD;
      end else baud_d = baud_q - 12'd1;
      RECV: if (baud_q == 12'd0) begin
        shft_d = {rx_s, shft_q[8:1]};
        bit_d  = bit_q + 4'd1;
        baud_d = BAUD_LD;
        if (bit_q == 4'd8) begin
          state_d = IDLE;
          data_d  = shft_d[7:0];
          done    = 1'b1;
        end
      end else baud_d = baud_q - 12'd1;
      default: state_d = IDLE;
    endcase
  end
  assign rdy_d = done | (rdy_q & ~start & ~clr_rdy);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 12'd0;
      bit_q   <= 4'd0;
      shft_q  <= 9'h1FF;
      data_q  <= 8'hFF;
      rdy_q   <= 1'b0;
      rx_d_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shft_q  <= shft_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      rx_d_q  <= rx_s;
    end
  end
  assign rx_data = data_q;
  assign rdy     = rdy_q;
`ifdef UART_RX_FRM_ERR_EN
  logic frm_q, frm_d;
  assign frm_d = done ? ~rx_s : frm_q & ~start & ~clr_rdy;
  always_ff @(posedge clk)
    frm_q <= rst ? 1'b0 : frm_d;
  assign frm_err = frm_q;
`else
  assign frm_err = 1'b0;
`endif
endmodule
